// File: rtl/dual_seq_detector_p_if.sv
// Bus bundle for dual_seq_detector_p: serial stream, channel configuration,
// sticky-flag control and the match/count results.
interface dual_seq_detector_p_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
);
  logic               seq_valid;
  logic               seq;
  logic               cfg_we;
  logic               cfg_sel;
  logic [MAX_LEN-1:0] cfg_pat;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_ovl;
  logic               clr_sticky;
  logic [1:0]         match;
  logic               d_out;
  logic [CNT_W-1:0]   cnt0;
  logic [CNT_W-1:0]   cnt1;

  modport master (
    output seq_valid, seq, cfg_we, cfg_sel, cfg_pat, cfg_len, cfg_ovl, clr_sticky,
    input  match, d_out, cnt0, cnt1
  );

  modport slave (
    input  seq_valid, seq, cfg_we, cfg_sel, cfg_pat, cfg_len, cfg_ovl, clr_sticky,
    output match, d_out, cnt0, cnt1
  );
endinterface

// File: rtl/dual_seq_detector_p.sv
// Two run-time programmable serial pattern detectors sharing one bit history,
// with per-channel overlap mode, saturating match counters and a sticky flag.
module dual_seq_detector_p #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input logic                clk,
  input logic                rst,
  dual_seq_detector_p_if.slave bus
);

  typedef struct packed {
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;
  } chan_cfg_t;

  chan_cfg_t          cfg_q  [2];
  logic [LEN_W-1:0]   fill_q [2];
  logic [CNT_W-1:0]   cnt_q  [2];
  // The oldest history bit is shifted out before it can ever be compared,
  // so only MAX_LEN-1 bits are stored; the incoming bit completes the window.
  logic [MAX_LEN-2:0] hist_q;
  logic [MAX_LEN-1:0] win;
  logic [MAX_LEN-1:0] mask [2];
  logic [1:0]         enabled, filled, cfg_hit, hit;
  logic [1:0]         match_q;
  logic               d_q;

  assign win = {hist_q, bus.seq};

  always_comb begin
    // NOTE: every signal driven here gets a value on every pass, so no latch is inferred.
    hit = '0;
    for (int k = 0; k < 2; k++) begin
      mask[k] = '0;
      for (int i = 0; i < MAX_LEN; i++) mask[k][i] = (i < int'(cfg_q[k].len));
      enabled[k] = (cfg_q[k].len != '0) && (int'(cfg_q[k].len) <= MAX_LEN);
      filled[k]  = (int'(fill_q[k]) + 1 >= int'(cfg_q[k].len));
      cfg_hit[k] = bus.cfg_we && (bus.cfg_sel == k[0]);
      hit[k]     = bus.seq_valid && !cfg_hit[k] && enabled[k] && filled[k] &&
                   (((win ^ cfg_q[k].pat) & mask[k]) == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: registers update with <= so every one samples pre-edge values, independent of statement order.
      hist_q  <= '0;
      match_q <= '0;
      d_q     <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        cfg_q[k]  <= '0;
        fill_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      if (bus.seq_valid) hist_q <= win[MAX_LEN-2:0];
      match_q <= hit;
      // A new match outranks a simultaneous clear.
      if (|hit)                d_q <= 1'b1;
      else if (bus.clr_sticky) d_q <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (cfg_hit[k]) begin
          cfg_q[k]  <= '{pat: bus.cfg_pat, len: bus.cfg_len, ovl: bus.cfg_ovl};
          fill_q[k] <= '0;
        end else if (bus.seq_valid) begin
          if (hit[k] && !cfg_q[k].ovl)         fill_q[k] <= '0;
          else if (int'(fill_q[k]) < MAX_LEN) fill_q[k] <= fill_q[k] + LEN_W'(1);
        end
        if (hit[k] && (cnt_q[k] != '1)) cnt_q[k] <= cnt_q[k] + CNT_W'(1);
      end
    end
  end

  assign bus.match = match_q;
  assign bus.d_out = d_q;
  assign bus.cnt0  = cnt_q[0];
  assign bus.cnt1  = cnt_q[1];

endmodule

// File: tb/tb_dual_seq_detector_p.sv
// Self-checking bench for dual_seq_detector_p: directed vector table, gapped and
// saturation sequences, then random traffic against a queue-based reference model.
module tb_dual_seq_detector_p;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_S   = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dual_seq_detector_p_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();
  dual_seq_detector_p_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_S)) bus_s ();

  assign bus_s.seq_valid  = bus.seq_valid;
  assign bus_s.seq        = bus.seq;
  assign bus_s.cfg_we     = bus.cfg_we;
  assign bus_s.cfg_sel    = bus.cfg_sel;
  assign bus_s.cfg_pat    = bus.cfg_pat;
  assign bus_s.cfg_len    = bus.cfg_len;
  assign bus_s.cfg_ovl    = bus.cfg_ovl;
  assign bus_s.clr_sticky = bus.clr_sticky;

  dual_seq_detector_p #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  dual_seq_detector_p #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_S)) dut_s (
    .clk (clk), .rst (rst), .bus (bus_s)
  );

  // ---------------- reference model: bits received per channel since restart
  bit         mq [2][$];
  logic [7:0] mpat [2];
  int         mlen [2];
  bit         movl [2];
  int         mc [2];
  int         mcs [2];
  bit         md;
  bit [1:0]   mm;

  function automatic void model_step(input logic r, v, s, we, sel,
                                     input logic [7:0] pat, input logic [3:0] len,
                                     input logic ovl, clr);
    bit [1:0] hit;
    hit = '0;
    if (!r) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete(); mpat[k] = '0; mlen[k] = 0; movl[k] = 0; mc[k] = 0; mcs[k] = 0;
      end
      md = 0; mm = '0;
      return;
    end
    for (int k = 0; k < 2; k++) begin
      bit here;
      here = we && (sel == k[0]);
      if (v && !here) begin
        mq[k].push_back(s);
        if (mq[k].size() > MAX_LEN) void'(mq[k].pop_front());
        if (mlen[k] >= 1 && mlen[k] <= MAX_LEN && mq[k].size() >= mlen[k]) begin
          bit same;
          same = 1;
          // newest bit pairs with pat[0], the one len-1 back with pat[len-1]
          for (int j = 0; j < mlen[k]; j++)
            if (mq[k][mq[k].size() - 1 - j] != mpat[k][j]) same = 0;
          if (same) begin
            hit[k] = 1;
            if (!movl[k]) mq[k].delete();
          end
        end
      end
      if (here) begin
        mpat[k] = pat; mlen[k] = int'(len); movl[k] = ovl; mq[k].delete();
      end
      if (hit[k]) begin
        if (mc[k] < 255) mc[k]++;
        if (mcs[k] < 3)  mcs[k]++;
      end
    end
    mm = hit;
    if (|hit)     md = 1;
    else if (clr) md = 0;
  endfunction

  // ---------------- check / drive helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, v, s, we, sel, input logic [7:0] pat,
                       input logic [3:0] len, input logic ovl, clr);
    rst = r; bus.seq_valid = v; bus.seq = s; bus.cfg_we = we; bus.cfg_sel = sel;
    bus.cfg_pat = pat; bus.cfg_len = len; bus.cfg_ovl = ovl; bus.clr_sticky = clr;
    model_step(r, v, s, we, sel, pat, len, ovl, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic d_bit(input logic s, input logic clr);
    drive(1, 1, s, 0, 0, 8'h00, 4'd0, 0, clr);
  endtask

  task automatic d_cfg(input logic sel, input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    drive(1, 0, 0, 1, sel, pat, len, ovl, 0);
  endtask

  task automatic d_idle(input logic clr);
    drive(1, 0, 0, 0, 0, 8'h00, 4'd0, 0, clr);
  endtask

  // ---------------- directed vector table
  typedef struct {
    logic       r, v, s, we, sel;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl, clr;
    logic [1:0] em;
    logic       ed;
    logic [7:0] c0, c1;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, v, s, we, sel, input logic [7:0] pat,
                              input logic [3:0] len, input logic ovl, clr,
                              input logic [1:0] em, input logic ed, input logic [7:0] c0, c1);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.we = we; t.sel = sel; t.pat = pat; t.len = len;
    t.ovl = ovl; t.clr = clr; t.em = em; t.ed = ed; t.c0 = c0; t.c1 = c1;
    vecs.push_back(t);
  endfunction

  function automatic void vbit(input logic s, input logic [1:0] em, input logic ed, input logic [7:0] c0, c1);
    add(1, 1, s, 0, 0, 8'h00, 4'd0, 0, 0, em, ed, c0, c1);
  endfunction

  function automatic void vcfg(input logic sel, input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                               input logic ed, input logic [7:0] c0, c1);
    add(1, 0, 0, 1, sel, pat, len, ovl, 0, 2'b00, ed, c0, c1);
  endfunction

  initial begin
    int pulses;

    // reset, then ch0 = 011 ovl, ch1 = 1001 ovl; stream 0,1,1
    add(0, 0, 0, 0, 0, 8'h00, 4'd0, 0, 0, 2'b00, 0, 0, 0);
    vcfg(0, 8'b011, 4'd3, 1, 0, 0, 0);
    vcfg(1, 8'b1001, 4'd4, 1, 0, 0, 0);
    vbit(0, 2'b00, 0, 0, 0);
    vbit(1, 2'b00, 0, 0, 0);
    vbit(1, 2'b01, 1, 1, 0);
    add(1, 0, 0, 0, 0, 8'h00, 4'd0, 0, 0, 2'b00, 1, 1, 0);
    add(1, 0, 0, 0, 0, 8'h00, 4'd0, 0, 1, 2'b00, 0, 1, 0);
    // ch1 overlapping: 1,0,0,1,0,0,1 -> pulses after bits 4 and 7
    vbit(1, 2'b00, 0, 1, 0);
    vbit(0, 2'b00, 0, 1, 0);
    vbit(0, 2'b00, 0, 1, 0);
    vbit(1, 2'b10, 1, 1, 1);
    vbit(0, 2'b00, 1, 1, 1);
    vbit(0, 2'b00, 1, 1, 1);
    vbit(1, 2'b10, 1, 1, 2);
    // ch1 non-overlapping replay; first bit completes 011 for ch0
    vcfg(1, 8'b1001, 4'd4, 0, 1, 1, 2);
    vbit(1, 2'b01, 1, 2, 2);
    vbit(0, 2'b00, 1, 2, 2);
    vbit(0, 2'b00, 1, 2, 2);
    vbit(1, 2'b10, 1, 2, 3);
    vbit(0, 2'b00, 1, 2, 3);
    vbit(0, 2'b00, 1, 2, 3);
    vbit(1, 2'b00, 1, 2, 3);
    // ch0 = 11: overlapping gives 3 pulses over 1,1,1,1
    vcfg(0, 8'b11, 4'd2, 1, 1, 2, 3);
    vbit(1, 2'b00, 1, 2, 3);
    vbit(1, 2'b01, 1, 3, 3);
    vbit(1, 2'b01, 1, 4, 3);
    vbit(1, 2'b01, 1, 5, 3);
    // non-overlapping gives 2 pulses
    vcfg(0, 8'b11, 4'd2, 0, 1, 5, 3);
    vbit(1, 2'b00, 1, 5, 3);
    vbit(1, 2'b01, 1, 6, 3);
    vbit(1, 2'b00, 1, 6, 3);
    vbit(1, 2'b01, 1, 7, 3);
    // reset mid-pattern discards history and configuration
    vcfg(0, 8'b011, 4'd3, 1, 1, 7, 3);
    vbit(0, 2'b00, 1, 7, 3);
    vbit(1, 2'b00, 1, 7, 3);
    add(0, 0, 0, 0, 0, 8'h00, 4'd0, 0, 0, 2'b00, 0, 0, 0);
    vbit(1, 2'b00, 0, 0, 0);
    vbit(0, 2'b00, 0, 0, 0);
    vbit(1, 2'b00, 0, 0, 0);
    vbit(1, 2'b00, 0, 0, 0);
    // length 0 and MAX_LEN+1 never match; length MAX_LEN does
    vcfg(0, 8'h00, 4'd0, 1, 0, 0, 0);
    vcfg(1, 8'h00, 4'(MAX_LEN + 1), 1, 0, 0, 0);
    for (int i = 0; i < MAX_LEN + 1; i++) vbit(0, 2'b00, 0, 0, 0);
    vcfg(1, 8'h00, 4'(MAX_LEN), 1, 0, 0, 0);
    for (int i = 0; i < MAX_LEN - 1; i++) vbit(0, 2'b00, 0, 0, 0);
    vbit(0, 2'b10, 1, 0, 1);
    vbit(0, 2'b10, 1, 0, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].v, vecs[i].s, vecs[i].we, vecs[i].sel,
            vecs[i].pat, vecs[i].len, vecs[i].ovl, vecs[i].clr);
      check($sformatf("vec%0d match", i), 32'(bus.match), 32'(vecs[i].em));
      check($sformatf("vec%0d d_out", i), 32'(bus.d_out), 32'(vecs[i].ed));
      check($sformatf("vec%0d cnt0", i),  32'(bus.cnt0),  32'(vecs[i].c0));
      check($sformatf("vec%0d cnt1", i),  32'(bus.cnt1),  32'(vecs[i].c1));
    end

    // gapped stream: 0,1,1 with three idle cycles between bits -> one pulse
    drive(0, 0, 0, 0, 0, 8'h00, 4'd0, 0, 0);
    d_cfg(0, 8'b011, 4'd3, 1);
    pulses = 0;
    for (int b = 0; b < 3; b++) begin
      d_bit((b == 0) ? 1'b0 : 1'b1, 0);
      pulses += int'(bus.match[0]);
      check($sformatf("gap bit%0d match", b), 32'(bus.match), (b == 2) ? 32'd1 : 32'd0);
      for (int g = 0; g < 3; g++) begin
        d_idle(0);
        pulses += int'(bus.match[0]);
      end
    end
    check("gap pulse count", 32'(pulses), 32'd1);

    // reconfigure ch0 on the 2nd bit: ch0 restarts, ch1 (01) still sees the bit
    d_cfg(1, 8'b01, 4'd2, 1);
    d_cfg(0, 8'b011, 4'd3, 1);
    d_bit(0, 0);
    check("cfg-cycle bit1 match", 32'(bus.match), 32'd0);
    drive(1, 1, 1, 1, 0, 8'b011, 4'd3, 1, 0);
    check("cfg-cycle bit2 match", 32'(bus.match), 32'b10);
    d_bit(1, 0);
    check("cfg-cycle bit3 match", 32'(bus.match), 32'd0);
    check("cfg-cycle cnt0", 32'(bus.cnt0), 32'd1);
    check("cfg-cycle cnt1", 32'(bus.cnt1), 32'd1);

    // 2-bit counter saturation and sticky set-beats-clear
    drive(0, 0, 0, 0, 0, 8'h00, 4'd0, 0, 0);
    d_cfg(0, 8'b1, 4'd1, 1);
    for (int b = 0; b < 5; b++) begin
      d_bit(1, (b == 4));
      check($sformatf("sat bit%0d match", b), 32'(bus_s.match), 32'd1);
      check($sformatf("sat bit%0d cnt0", b), 32'(bus_s.cnt0), (b < 3) ? 32'(b + 1) : 32'd3);
      check($sformatf("sat bit%0d wide cnt0", b), 32'(bus.cnt0), 32'(b + 1));
      check($sformatf("sat bit%0d d_out", b), 32'(bus_s.d_out), 32'd1);
    end
    d_idle(1);
    check("clear alone d_out", 32'(bus_s.d_out), 32'd0);
    check("clear alone match", 32'(bus_s.match), 32'd0);

    // random traffic against the reference model
    drive(0, 0, 0, 0, 0, 8'h00, 4'd0, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      logic r, v, s, we, sel, ovl, clr;
      logic [7:0] pat;
      logic [3:0] len;
      r   = ($urandom_range(0, 499) != 0);
      v   = ($urandom_range(0, 3) != 0);
      s   = 1'($urandom_range(0, 1));
      we  = ($urandom_range(0, 7) == 0);
      sel = 1'($urandom_range(0, 1));
      pat = 8'($urandom);
      len = 4'($urandom_range(0, MAX_LEN + 1));
      ovl = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 9) == 0);
      drive(r, v, s, we, sel, pat, len, ovl, clr);
      check("rand match", 32'(bus.match), 32'(mm));
      check("rand d_out", 32'(bus.d_out), 32'(md));
      check("rand cnt0",  32'(bus.cnt0),  32'(mc[0]));
      check("rand cnt1",  32'(bus.cnt1),  32'(mc[1]));
      check("rand sat cnt0", 32'(bus_s.cnt0), 32'(mcs[0]));
      check("rand sat cnt1", 32'(bus_s.cnt1), 32'(mcs[1]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dual_seq_detector_p.md
Name: dual_seq_detector_p

Overview:
Parametrised successor to the team's fixed dual-sequence FSM detector. Two independent channels each hold a run-time programmable bit pattern of length 1..MAX_LEN and a per-channel overlap/non-overlap mode, and both scan one serial bit stream. Outputs are a per-channel one-cycle match pulse, per-channel saturating match counters, and a sticky combined flag d_out. The block sits on the serial input path ahead of the control logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
LEN_W, 4, width of length fields; must hold MAX_LEN
CNT_W, 8, width of each match counter

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous reset, active-low (rst==0 resets on posedge clk)
seq_valid  input  1  seq is sampled when high
seq  input  1  serial data bit
cfg_we  input  1  configuration write strobe
cfg_sel  input  1  channel written (0/1)
cfg_pat  input  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
cfg_len  input  LEN_W  pattern length
cfg_ovl  input  1  1 = overlapping detection, 0 = non-overlapping
clr_sticky  input  1  clears d_out
match  output  2  match[k] is a one-cycle pulse for channel k
d_out  output  1  sticky: any match since last clear
cnt0  output  CNT_W  channel 0 match count, saturating
cnt1  output  CNT_W  channel 1 match count, saturating

Behaviour:
- Reset (rst==0 at posedge): all patterns, lengths, ovl bits, history, fill counters, match, d_out, cnt0 and cnt1 go to 0. Length 0 means both channels are disabled after reset.
- History: shared MAX_LEN-bit shift register. On an accepted bit (seq_valid=1): hist <= {hist[MAX_LEN-2:0], seq}. Define win = {hist[MAX_LEN-2:0], seq}.
- Fill: each channel k has fill_k, which counts accepted bits since the last restart and saturates at MAX_LEN.
- Match condition for channel k, all on the same accepted bit:
  - len_k is in 1..MAX_LEN, and
  - fill_k+1 >= len_k, and
  - the low len_k bits of win equal the low len_k bits of pat_k.
  - len_k = 0 or len_k > MAX_LEN: channel disabled, never matches.
- Latency: match[k] is registered and goes high exactly 1 cycle after the clock edge that accepted the completing bit. It stays high for one cycle only. Back-to-back matches give consecutive pulses.
- Overlap mode (ovl_k=1): fill_k keeps counting after a match, so suffix bits can begin the next match.
- Non-overlap mode (ovl_k=0): on a match, fill_k goes to 0, so the next match needs len_k fresh bits.
- seq_valid=0: history, fill and match conditions are unchanged; match is 0 on the next cycle.
- Configuration write (cfg_we=1): at the posedge, pat, len and ovl of channel cfg_sel load from cfg_*, and that channel's fill goes to 0. Its counter is kept. The other channel is unaffected.
  - If seq_valid=1 in the same cycle, the bit still enters history and still counts for the other channel.
  - The channel being configured does not evaluate a match in that cycle and does not count the bit.
- Counters: cntk increments on every match[k] pulse and saturates at 2^CNT_W-1 (no wrap).
- d_out: set in the cycle after any match (same timing as match), cleared by clr_sticky. If set and clear happen in the same cycle, set wins.
- Both channels matching on the same bit: both pulses fire together and both counters increment.
- Reset mid-stream: partial sequences are discarded, and configuration must be rewritten.

Test Plan:
1. Ch0 = 011 (len 3, ovl), ch1 = 1001 (len 4, ovl). Stream 0,1,1 -> match[0] pulses 1 cycle after the 3rd bit, cnt0=1, d_out=1, match[1]=0.
2. Ch1 = 1001. Stream 1,0,0,1,0,0,1 -> ovl=1 gives pulses after bits 4 and 7, cnt1=2. Reprogram with ovl=0 and replay -> one pulse only, after bit 4, cnt1 increases by 1.
3. Ch0 = 11 (len 2), stream 1,1,1,1 -> ovl=1 gives 3 pulses on consecutive cycles. ovl=0 gives 2 pulses (after bits 2 and 4).
4. Ch0 = 011 with seq_valid low for 3 cycles between each bit -> exactly one pulse, 1 cycle after the 3rd valid bit. cfg_we to ch0 coinciding with the 2nd bit -> no match on the 3rd bit.
5. CNT_W=2, ch0 = 1 (len 1), 5 accepted 1s -> cnt0 reads 1,2,3,3,3. Assert clr_sticky together with a match -> d_out stays 1; clr_sticky alone -> d_out=0 next cycle.
6. rst=0 for one cycle after bits 0,1 of 011, then rst=1 and bit 1 -> no match, all outputs 0, channels disabled (len 0). Lengths 0 and MAX_LEN+1 never match.
